// File: rtl/branch_pkg.sv
// Shared types and defaults for the commit-side branch resolver slice.
package branch_pkg;
  localparam int unsigned BR_ADDR_W = 17;
  localparam int unsigned BR_DEPTH  = 4;

  typedef struct packed {
    logic [BR_ADDR_W-1:0] addr;
    logic                 take;
  } br_entry_t;

  function automatic logic [31:0] redirect_pc(input logic [31:0] pc,
                                              input logic        real_take,
                                              input logic [31:0] target);
    return real_take ? target : pc + 32'd4;
  endfunction
endpackage

// File: rtl/branch_resolver_if.sv
// Commit lanes in, predictor update / redirect / statistics out.
interface branch_resolver_if import branch_pkg::*; #(
  parameter int unsigned ADDR_W = BR_ADDR_W
);
  logic              c0_valid;
  logic [31:0]       c0_pc;
  logic              c0_pred_take;
  logic              c0_real_take;
  logic [31:0]       c0_target;
  logic              c1_valid;
  logic [31:0]       c1_pc;
  logic              c1_pred_take;
  logic              c1_real_take;
  logic [31:0]       c1_target;
  logic              commit_ready;
  logic              branch_record_en;
  logic [ADDR_W-1:0] branch_address;
  logic              branch_take;
  logic              flush_en;
  logic [31:0]       flush_pc;
  logic [31:0]       br_total;
  logic [31:0]       br_miss;

  modport master (
    output c0_valid, c0_pc, c0_pred_take, c0_real_take, c0_target,
    output c1_valid, c1_pc, c1_pred_take, c1_real_take, c1_target,
    input  commit_ready, branch_record_en, branch_address, branch_take,
    input  flush_en, flush_pc, br_total, br_miss
  );

  modport slave (
    input  c0_valid, c0_pc, c0_pred_take, c0_real_take, c0_target,
    input  c1_valid, c1_pc, c1_pred_take, c1_real_take, c1_target,
    output commit_ready, branch_record_en, branch_address, branch_take,
    output flush_en, flush_pc, br_total, br_miss
  );
endinterface

// File: rtl/br_record_fifo.sv
// Circular record buffer: up to two ordered writes and one read per cycle.
module br_record_fifo import branch_pkg::*; #(
  parameter int unsigned DEPTH = BR_DEPTH,
  parameter int unsigned W     = BR_ADDR_W + 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic [1:0]               push_cnt,
  input  logic [W-1:0]             wr_data0,
  input  logic [W-1:0]             wr_data1,
  input  logic                     pop,
  output logic [W-1:0]             rd_data,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (en) begin
      wr_ptr <= wr_ptr + PW'(push_cnt);
      rd_ptr <= rd_ptr + PW'(pop);
      count  <= count + CW'(push_cnt) - CW'(pop);
    end
  end

  // Storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (en) begin
      if (push_cnt != 2'd0) mem[wr_ptr] <= wr_data0;
      if (push_cnt == 2'd2) mem[wr_ptr + PW'(1)] <= wr_data1;
    end
  end

  assign rd_data = mem[rd_ptr];
endmodule

// File: rtl/branch_resolver.sv
// Accepts up to two committed branches per cycle, feeds the predictor one
// record per cycle, and raises a registered redirect on mispredict.
module branch_resolver import branch_pkg::*; #(
  parameter int unsigned DEPTH  = BR_DEPTH,
  parameter int unsigned ADDR_W = BR_ADDR_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hci_rdy,
  branch_resolver_if.slave bus
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned EW = ADDR_W + 1;

  logic [CW-1:0] count;
  logic          commit_ready;
  logic          m0, m1, a0, a1, miss0, miss1, pop;
  logic [1:0]    push_cnt;
  logic [EW-1:0] e0, e1, wd0, rd_data;
  logic          flush_en_q;
  logic [31:0]   flush_pc_q, br_total_q, br_miss_q;

  assign commit_ready = (count <= CW'(DEPTH - 2));
  assign pop          = hci_rdy && (count != '0);

  always_comb begin
    m0       = bus.c0_pred_take != bus.c0_real_take;
    m1       = bus.c1_pred_take != bus.c1_real_take;
    a0       = hci_rdy && commit_ready && bus.c0_valid;
    // Anything younger than a lane-0 mispredict is on the wrong path.
    a1       = hci_rdy && commit_ready && bus.c1_valid && !(bus.c0_valid && m0);
    miss0    = a0 && m0;
    miss1    = a1 && m1;
    push_cnt = {1'b0, a0} + {1'b0, a1};
    e0       = {bus.c0_pc[ADDR_W-1:0], bus.c0_real_take};
    e1       = {bus.c1_pc[ADDR_W-1:0], bus.c1_real_take};
    wd0      = a0 ? e0 : e1;
  end

  br_record_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (hci_rdy),
    .push_cnt (push_cnt),
    .wr_data0 (wd0),
    .wr_data1 (e1),
    .pop      (pop),
    .rd_data  (rd_data),
    .count    (count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flush_en_q <= 1'b0;
      flush_pc_q <= '0;
      br_total_q <= '0;
      br_miss_q  <= '0;
    end else if (hci_rdy) begin
      flush_en_q <= miss0 || miss1;
      if (miss0)
        flush_pc_q <= redirect_pc(bus.c0_pc, bus.c0_real_take, bus.c0_target);
      else if (miss1)
        flush_pc_q <= redirect_pc(bus.c1_pc, bus.c1_real_take, bus.c1_target);
      br_total_q <= br_total_q + 32'(push_cnt);
      br_miss_q  <= br_miss_q + 32'(miss0 || miss1);
    end
  end

  assign bus.commit_ready     = commit_ready;
  assign bus.branch_record_en = pop;
  assign bus.branch_address   = rd_data[EW-1:1];
  assign bus.branch_take      = rd_data[0];
  assign bus.flush_en         = flush_en_q;
  assign bus.flush_pc         = flush_pc_q;
  assign bus.br_total         = br_total_q;
  assign bus.br_miss          = br_miss_q;
endmodule

// File: tb/tb_branch_resolver.sv
// Self-checking bench for branch_resolver: directed scenarios plus a random
// run against a queue-based reference model.
module tb_branch_resolver;
  import branch_pkg::*;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned ADDR_W = 17;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic hci_rdy = 1'b0;
  always #5 clk = ~clk;

  branch_resolver_if #(.ADDR_W(ADDR_W)) bus ();
  branch_resolver #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .hci_rdy (hci_rdy),
    .bus     (bus)
  );

  int unsigned vectors = 0;
  int unsigned errors  = 0;

  // Reference model: pending records in commit order plus architectural outputs.
  br_entry_t   mq[$];
  logic        m_flush_en;
  logic [31:0] m_flush_pc, m_total, m_miss;
  // Snapshot taken just before each active edge, and what the model expected.
  logic        pre_ready, pre_en, exp_ready, exp_en;
  br_entry_t   pre_rec, exp_rec;

  task automatic model_clear();
    mq.delete();
    m_flush_en = 1'b0;
    m_flush_pc = '0;
    m_total    = '0;
    m_miss     = '0;
  endtask

  task automatic idle_lanes();
    bus.c0_valid = 0; bus.c0_pc = '0; bus.c0_pred_take = 0; bus.c0_real_take = 0; bus.c0_target = '0;
    bus.c1_valid = 0; bus.c1_pc = '0; bus.c1_pred_take = 0; bus.c1_real_take = 0; bus.c1_target = '0;
  endtask

  task automatic set_lane(input int lane, input logic v, input logic [31:0] pc,
                          input logic pred, input logic rl, input logic [31:0] tgt);
    if (lane == 0) begin
      bus.c0_valid = v; bus.c0_pc = pc; bus.c0_pred_take = pred; bus.c0_real_take = rl; bus.c0_target = tgt;
    end else begin
      bus.c1_valid = v; bus.c1_pc = pc; bus.c1_pred_take = pred; bus.c1_real_take = rl; bus.c1_target = tgt;
    end
  endtask

  // Called at a falling edge with inputs already driven; returns at the next falling edge.
  task automatic step();
    br_entry_t tmp;
    logic      blocked;
    #1;
    pre_ready    = bus.commit_ready;
    pre_en       = bus.branch_record_en;
    pre_rec.addr = bus.branch_address;
    pre_rec.take = bus.branch_take;
    exp_ready    = (mq.size() <= DEPTH - 2);
    exp_en       = hci_rdy && (mq.size() != 0);
    exp_rec      = (mq.size() != 0) ? mq[0] : '0;
    if (hci_rdy) begin
      if (mq.size() != 0) tmp = mq.pop_front();
      m_flush_en = 1'b0;
      if (exp_ready) begin
        blocked = 1'b0;
        if (bus.c0_valid) begin
          mq.push_back('{bus.c0_pc[ADDR_W-1:0], bus.c0_real_take});
          m_total++;
          if (bus.c0_pred_take != bus.c0_real_take) begin
            m_miss++;
            m_flush_en = 1'b1;
            m_flush_pc = bus.c0_real_take ? bus.c0_target : bus.c0_pc + 32'd4;
            blocked    = 1'b1;
          end
        end
        if (bus.c1_valid && !blocked) begin
          mq.push_back('{bus.c1_pc[ADDR_W-1:0], bus.c1_real_take});
          m_total++;
          if (bus.c1_pred_take != bus.c1_real_take) begin
            m_miss++;
            m_flush_en = 1'b1;
            m_flush_pc = bus.c1_real_take ? bus.c1_target : bus.c1_pc + 32'd4;
          end
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle_lanes();
    hci_rdy = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_clear();
  endtask

  task automatic test_reset();
    idle_lanes();
    hci_rdy = 1'b1;
    rst_n   = 1'b0;
    #7;
    vectors++; if (bus.commit_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got=%b exp=1", bus.commit_ready); end
    vectors++; if (bus.branch_record_en !== 1'b0) begin errors++; $display("FAIL rst_rec_en got=%b exp=0", bus.branch_record_en); end
    vectors++; if (bus.br_total !== 32'd0) begin errors++; $display("FAIL rst_total got=%0d exp=0", bus.br_total); end
    vectors++; if (bus.br_miss !== 32'd0) begin errors++; $display("FAIL rst_miss got=%0d exp=0", bus.br_miss); end
    vectors++; if (bus.flush_en !== 1'b0) begin errors++; $display("FAIL rst_flush_en got=%b exp=0", bus.flush_en); end
    vectors++; if (bus.flush_pc !== 32'd0) begin errors++; $display("FAIL rst_flush_pc got=%h exp=0", bus.flush_pc); end
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    step();
    step();
    vectors++; if (pre_ready !== 1'b1) begin errors++; $display("FAIL idle_ready got=%b exp=1", pre_ready); end
    vectors++; if (pre_en !== 1'b0) begin errors++; $display("FAIL idle_rec_en got=%b exp=0", pre_en); end
    vectors++; if (bus.br_total !== 32'd0) begin errors++; $display("FAIL idle_total got=%0d exp=0", bus.br_total); end
    vectors++; if (bus.flush_en !== 1'b0) begin errors++; $display("FAIL idle_flush_en got=%b exp=0", bus.flush_en); end
  endtask

  task automatic test_dual_correct();
    do_reset();
    set_lane(0, 1, 32'h0000_1000, 1, 1, 32'h0000_1100);
    set_lane(1, 1, 32'h0000_1008, 0, 0, 32'h0000_1200);
    step();
    idle_lanes();
    vectors++; if (bus.br_total !== 32'd2) begin errors++; $display("FAIL dual_total got=%0d exp=2", bus.br_total); end
    vectors++; if (bus.br_miss !== 32'd0) begin errors++; $display("FAIL dual_miss got=%0d exp=0", bus.br_miss); end
    vectors++; if (bus.flush_en !== 1'b0) begin errors++; $display("FAIL dual_flush got=%b exp=0", bus.flush_en); end
    step();
    vectors++; if ({pre_en, pre_rec} !== {1'b1, 17'h01000, 1'b1}) begin errors++; $display("FAIL dual_rec0 got=%b/%h/%b exp=1/01000/1", pre_en, pre_rec.addr, pre_rec.take); end
    step();
    vectors++; if ({pre_en, pre_rec} !== {1'b1, 17'h01008, 1'b0}) begin errors++; $display("FAIL dual_rec1 got=%b/%h/%b exp=1/01008/0", pre_en, pre_rec.addr, pre_rec.take); end
    step();
    vectors++; if (pre_en !== 1'b0) begin errors++; $display("FAIL dual_empty got=%b exp=0", pre_en); end
  endtask

  task automatic test_lane0_mispredict();
    do_reset();
    set_lane(0, 1, 32'h0000_2000, 0, 1, 32'h0000_3000);
    set_lane(1, 1, 32'h0000_2010, 0, 0, 32'h0000_4000);
    step();
    idle_lanes();
    vectors++; if (bus.flush_en !== 1'b1) begin errors++; $display("FAIL l0m_flush_en got=%b exp=1", bus.flush_en); end
    vectors++; if (bus.flush_pc !== 32'h0000_3000) begin errors++; $display("FAIL l0m_flush_pc got=%h exp=00003000", bus.flush_pc); end
    vectors++; if (bus.br_total !== 32'd1) begin errors++; $display("FAIL l0m_total got=%0d exp=1", bus.br_total); end
    vectors++; if (bus.br_miss !== 32'd1) begin errors++; $display("FAIL l0m_miss got=%0d exp=1", bus.br_miss); end
    step();
    vectors++; if (bus.flush_en !== 1'b0) begin errors++; $display("FAIL l0m_pulse got=%b exp=0", bus.flush_en); end
    vectors++; if ({pre_en, pre_rec} !== {1'b1, 17'h02000, 1'b1}) begin errors++; $display("FAIL l0m_rec got=%b/%h/%b exp=1/02000/1", pre_en, pre_rec.addr, pre_rec.take); end
    step();
    vectors++; if (pre_en !== 1'b0) begin errors++; $display("FAIL l0m_dropped got=%b exp=0", pre_en); end
  endtask

  task automatic test_lane1_wrap();
    do_reset();
    set_lane(0, 1, 32'h0000_4000, 1, 1, 32'h0000_5000);
    set_lane(1, 1, 32'hFFFF_FFFC, 1, 0, 32'h0000_6000);
    step();
    idle_lanes();
    vectors++; if (bus.flush_en !== 1'b1) begin errors++; $display("FAIL l1w_flush_en got=%b exp=1", bus.flush_en); end
    vectors++; if (bus.flush_pc !== 32'h0000_0000) begin errors++; $display("FAIL l1w_flush_pc got=%h exp=00000000", bus.flush_pc); end
    vectors++; if (bus.br_miss !== 32'd1) begin errors++; $display("FAIL l1w_miss got=%0d exp=1", bus.br_miss); end
    vectors++; if (bus.br_total !== 32'd2) begin errors++; $display("FAIL l1w_total got=%0d exp=2", bus.br_total); end
    step();
    step();
    vectors++; if ({pre_en, pre_rec} !== {1'b1, 17'h1FFFC, 1'b0}) begin errors++; $display("FAIL l1w_rec got=%b/%h/%b exp=1/1fffc/0", pre_en, pre_rec.addr, pre_rec.take); end
  endtask

  task automatic test_backpressure();
    logic [31:0] next_pc;
    logic        saw_stall;
    logic [ADDR_W-1:0] last_addr;
    do_reset();
    next_pc   = 32'h0000_0100;
    saw_stall = 1'b0;
    last_addr = '0;
    for (int c = 0; c < 8; c++) begin
      set_lane(0, 1, next_pc,         c[0], c[0], 32'h0);
      set_lane(1, 1, next_pc + 32'd4, 1'b0, 1'b0, 32'h0);
      step();
      if (pre_ready) next_pc = next_pc + 32'd8;
      if (!pre_ready) saw_stall = 1'b1;
      vectors++; if (pre_ready !== exp_ready) begin errors++; $display("FAIL bp_ready c=%0d got=%b exp=%b", c, pre_ready, exp_ready); end
      vectors++; if (pre_en !== exp_en || (exp_en && pre_rec !== exp_rec)) begin errors++; $display("FAIL bp_rec c=%0d got=%b/%h exp=%b/%h", c, pre_en, pre_rec, exp_en, exp_rec); end
      if (pre_en) begin
        vectors++; if (pre_rec.addr <= last_addr) begin errors++; $display("FAIL bp_order c=%0d got=%h after=%h", c, pre_rec.addr, last_addr); end
        last_addr = pre_rec.addr;
      end
    end
    vectors++; if (saw_stall !== 1'b1) begin errors++; $display("FAIL bp_stall got=%b exp=1", saw_stall); end
    idle_lanes();
    hci_rdy = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      vectors++; if (pre_en !== 1'b0) begin errors++; $display("FAIL bp_frozen_en c=%0d got=%b exp=0", c, pre_en); end
      vectors++; if (pre_ready !== exp_ready) begin errors++; $display("FAIL bp_frozen_ready c=%0d got=%b exp=%b", c, pre_ready, exp_ready); end
    end
    hci_rdy = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      vectors++; if (pre_en !== exp_en || (exp_en && pre_rec !== exp_rec)) begin errors++; $display("FAIL bp_drain c=%0d got=%b/%h exp=%b/%h", c, pre_en, pre_rec, exp_en, exp_rec); end
    end
  endtask

  task automatic test_async_reset_mid_drain();
    do_reset();
    set_lane(0, 1, 32'h0000_0500, 0, 0, 32'h0);
    set_lane(1, 1, 32'h0000_0504, 1, 1, 32'h0);
    step();
    set_lane(0, 1, 32'h0000_0508, 0, 0, 32'h0);
    set_lane(1, 1, 32'h0000_050C, 1, 1, 32'h0);
    step();
    idle_lanes();
    #2;
    vectors++; if ({bus.commit_ready, bus.branch_record_en} !== 2'b01) begin errors++; $display("FAIL ar_before got=%b%b exp=01", bus.commit_ready, bus.branch_record_en); end
    rst_n = 1'b0;
    #1;
    vectors++; if ({bus.commit_ready, bus.branch_record_en} !== 2'b10) begin errors++; $display("FAIL ar_during got=%b%b exp=10", bus.commit_ready, bus.branch_record_en); end
    vectors++; if (bus.br_total !== 32'd0) begin errors++; $display("FAIL ar_total got=%0d exp=0", bus.br_total); end
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    step();
    vectors++; if (pre_en !== 1'b0) begin errors++; $display("FAIL ar_after got=%b exp=0", pre_en); end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      logic r0, r1;
      hci_rdy = ($urandom_range(0, 7) != 0);
      r0 = $urandom_range(0, 1);
      r1 = $urandom_range(0, 1);
      set_lane(0, $urandom_range(0, 3) != 0, $urandom, r0 ^ ($urandom_range(0, 3) == 0), r0, $urandom);
      set_lane(1, $urandom_range(0, 2) != 0, $urandom, r1 ^ ($urandom_range(0, 3) == 0), r1, $urandom);
      step();
      vectors++; if (pre_ready !== exp_ready) begin errors++; $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, pre_ready, exp_ready); end
      vectors++; if (pre_en !== exp_en || (exp_en && pre_rec !== exp_rec)) begin errors++; $display("FAIL rnd_rec c=%0d got=%b/%h exp=%b/%h", c, pre_en, pre_rec, exp_en, exp_rec); end
      vectors++; if (bus.flush_en !== m_flush_en || bus.flush_pc !== m_flush_pc) begin errors++; $display("FAIL rnd_flush c=%0d got=%b/%h exp=%b/%h", c, bus.flush_en, bus.flush_pc, m_flush_en, m_flush_pc); end
      vectors++; if (bus.br_total !== m_total || bus.br_miss !== m_miss) begin errors++; $display("FAIL rnd_counters c=%0d got=%0d/%0d exp=%0d/%0d", c, bus.br_total, bus.br_miss, m_total, m_miss); end
    end
    idle_lanes();
    hci_rdy = 1'b1;
  endtask

  initial begin
    test_reset();
    test_dual_correct();
    test_lane0_mispredict();
    test_lane1_wrap();
    test_backpressure();
    test_async_reset_mid_drain();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
